// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - D-stage hazard unit: forwarding selects, load-use interlock, multiply occupancy, flush
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs_addr,
  input  logic [AW-1:0] d_rt_addr,
  input  logic          d_uses_rs,
  input  logic          d_uses_rt,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wr_addr,
  input  logic          d_is_load,
  input  logic          d_is_mul,
  input  logic          flush,
  output logic          stall,
  output logic          bubble,
  output logic          fwdX_rs,
  output logic          fwdX_rt,
  output logic          fwdM_rs,
  output logic          fwdM_rt,
  output logic          x_busy
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  // Shadow tags of the instructions currently in X and M
  logic          x_v, x_wr, x_ld;
  logic [AW-1:0] x_addr;
  logic          m_v, m_wr;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] cnt;
  mul_state_t    state;

  logic          x_v_n, x_wr_n, x_ld_n;
  logic [AW-1:0] x_addr_n;
  logic          m_v_n, m_wr_n;
  logic [AW-1:0] m_addr_n;
  logic [CW-1:0] cnt_n;
  mul_state_t    state_n;

  logic busy;
  logic hitx_rs, hitx_rt, hitm_rs, hitm_rt;
  logic lu;
  logic issue_mul;

  // Source/tag match; register 0 never matches so it is never forwarded or interlocked
  always_comb begin
    hitx_rs = x_v & x_wr & (x_addr == d_rs_addr) & (d_rs_addr != '0) & d_uses_rs;
    hitx_rt = x_v & x_wr & (x_addr == d_rt_addr) & (d_rt_addr != '0) & d_uses_rt;
    hitm_rs = m_v & m_wr & (m_addr == d_rs_addr) & (d_rs_addr != '0) & d_uses_rs;
    hitm_rt = m_v & m_wr & (m_addr == d_rt_addr) & (d_rt_addr != '0) & d_uses_rt;
  end

  // Output decode: busy beats flush beats load-use beats normal issue
  always_comb begin
    busy    = (state == BUSY);
    lu      = d_valid & (hitx_rs | hitx_rt) & x_ld;
    x_busy  = busy;
    // X holds during a multiply, so no bubble is inserted then
    bubble  = !busy & (flush | lu);
    stall   = busy | (!flush & lu);
    // A load in X has no result yet; the interlock covers that case instead
    fwdX_rs = hitx_rs & !x_ld;
    fwdX_rt = hitx_rt & !x_ld;
    // The newest producer wins, so M only forwards when X does not match
    fwdM_rs = hitm_rs & !hitx_rs;
    fwdM_rt = hitm_rt & !hitx_rt;
    issue_mul = !busy & d_valid & d_is_mul & !bubble;
  end

  // Next-state for the tag pipeline and the multiply occupancy FSM
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    x_v_n    = x_v;
    x_wr_n   = x_wr;
    x_ld_n   = x_ld;
    x_addr_n = x_addr;
    m_v_n    = m_v;
    m_wr_n   = m_wr;
    m_addr_n = m_addr;
    case (state)
      BUSY: begin
        // X tag frozen with the multiply; nothing drains into M meanwhile
        m_v_n = 1'b0;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = IDLE;
        end
      end
      default: begin
        m_v_n    = x_v;
        m_wr_n   = x_wr;
        m_addr_n = x_addr;
        if (bubble) begin
          x_v_n    = 1'b0;
          x_wr_n   = 1'b0;
          x_ld_n   = 1'b0;
          x_addr_n = '0;
        end else begin
          x_v_n    = d_valid;
          x_wr_n   = d_wr_en;
          x_ld_n   = d_is_load;
          x_addr_n = d_wr_addr;
        end
        if (issue_mul) begin
          cnt_n   = CW'(MUL_LAT - 1);
          state_n = BUSY;
        end
      end
    endcase
  end

  // State register; reset drops the multiply and invalidates both tags immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      x_v    <= 1'b0;
      x_wr   <= 1'b0;
      x_ld   <= 1'b0;
      x_addr <= '0;
      m_v    <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      x_v    <= x_v_n;
      x_wr   <= x_wr_n;
      x_ld   <= x_ld_n;
      x_addr <= x_addr_n;
      m_v    <= m_v_n;
      m_wr   <= m_wr_n;
      m_addr <= m_addr_n;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer side of the D→X forwarding interface. Generates bubble, fwdX_rs/rt and fwdM_rs/rt for the DX forwarding mux, plus stall for the F/D registers.
- Keeps its own shadow pipeline of destination tags for the X and M stages, so the datapath does not need to export them.
- Handles forwarding priority, load-use interlock, multi-cycle multiply occupancy of X, and branch flush.

Parameters:
- MUL_LAT, 3, cycles a multiply occupies X (≥2).
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  D stage holds a real instruction.
- d_rs_addr  in  AW  D-stage rs source.
- d_rt_addr  in  AW  D-stage rt source.
- d_uses_rs  in  1  instruction reads rs.
- d_uses_rt  in  1  instruction reads rt.
- d_wr_en  in  1  instruction writes a register.
- d_wr_addr  in  AW  destination register.
- d_is_load  in  1  load (result available after M).
- d_is_mul  in  1  multi-cycle multiply.
- flush  in  1  branch resolved taken in X; squash D.
- stall  out  1  hold PC and F/D registers.
- bubble  out  1  zero X input and XM control.
- fwdX_rs  out  1  select X-stage result for rs.
- fwdX_rt  out  1  select X-stage result for rt.
- fwdM_rs  out  1  select M-stage result for rs.
- fwdM_rt  out  1  select M-stage result for rt.
- x_busy  out  1  multiply occupying X.

Behaviour:
- State: X tag {v, wr, addr, ld}, M tag {v, wr, addr}, mul counter cnt (0..MUL_LAT-1). All outputs are combinational from state plus D inputs; no output latency.
- Reset (async): both tags invalid, cnt=0. Outputs then follow the D inputs only: fwd*=0, stall=0, bubble=0 (unless flush=1), x_busy=0.
- Match definitions:
  - hitX_s = X.v & X.wr & X.addr==src & src!=0 & d_uses_src.
  - hitM_s = the same test on the M tag.
- Forwarding:
  - fwdX_s = hitX_s & !X.ld.
  - fwdM_s = hitM_s & !hitX_s. X has priority; the newest producer wins.
  - Register 0 is never forwarded.
- Load-use: lu = d_valid & (hitX_rs | hitX_rt) & X.ld. When lu: stall=1, bubble=1.
- Multiply FSM:
  - IDLE (cnt=0): if a multiply is issued into X, load cnt=MUL_LAT-1 and go to BUSY.
  - BUSY: x_busy=1, stall=1, bubble=0 (X holds), X tag frozen, M tag next=invalid, cnt decrements; leave BUSY when cnt reaches 0.
  - With MUL_LAT=3, a multiply stalls D for 2 extra cycles.
- Priority, highest first:
  - busy
  - flush: bubble=1, stall=0, X next=invalid.
  - lu
  - normal issue.
  - flush during busy is ignored; a bench assertion flags it as an illegal input.
- Tag advance when not busy:
  - M ← X (v, wr, addr).
  - X ← D fields with v=d_valid, or invalid when bubble=1.
- Issue: the multiply counter loads only on a real issue (d_valid & d_is_mul & !bubble).
- Reset mid-multiply: cnt clears immediately and stall drops the same cycle.
- The X and M tags may both match the same source; fwdX wins. fwdM is still asserted for the other source if only M matches it.

Test Plan:
- Forward from X: I1 writes r5; next cycle D reads rs=r5 → fwdX_rs=1, fwdM_rs=0, stall=0.
- Priority: r5 written two cycles in a row, then read rt=r5 → fwdX_rt=1, fwdM_rt=0. Same sequence with an unrelated middle instruction → fwdM_rt=1.
- Load-use: load r7, then D reads r7 → stall=1, bubble=1 for 1 cycle; next cycle fwdM_rs=1, stall=0.
- r0 filter: writer to r0 followed by a reader of r0 → all fwd=0, no stall.
- Multiply, MUL_LAT=3: issue mul to r9 → x_busy=1 and stall=1 for 2 cycles, bubble=0. A dependent reader then sees fwdX=1.
- Flush and reset: flush=1 with D hitting a load in X → bubble=1, stall=0, X tag invalid. reset asserted mid-multiply → x_busy=0, stall=0 asynchronously.
